// File: rtl/dffram_ctrl.sv
// dffram_ctrl: valid/ready front end for a byte-writable DFFRAM port with one-cycle read and response hold.
// Define DFFRAM_CTRL_INIT_EN to zero the whole RAM after every reset before accepting requests.
module dffram_ctrl #(
  parameter int COLS = 1,
  localparam int A_WIDTH = 8 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               busy,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_we,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               ram_EN,
  output logic [3:0]         ram_WE,
  output logic [A_WIDTH-1:0] ram_A,
  output logic [31:0]        ram_Di,
  input  logic [31:0]        ram_Do
);
  logic run, init_on, rd_pend, hold_valid, accept;
  logic [A_WIDTH-1:0] init_a;
  logic [31:0] hold;
`ifdef DFFRAM_CTRL_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [A_WIDTH-1:0] cnt;
  always_ff @(posedge CLK)
    if (RST) begin
      state <= INIT;
      cnt <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == A_WIDTH'(256 * COLS - 1)) state <= RUN;
    end
  assign busy = state == INIT;
  assign run = state == RUN && !RST;
  assign init_on = busy && !RST;
  assign init_a = cnt;
`else
  assign busy = 1'b0;
  assign run = !RST;
  assign init_on = 1'b0;
  assign init_a = '0;
`endif
  // a pending read may only be followed by another request if its data leaves this cycle
  assign req_ready = run && !hold_valid && !(rd_pend && !rsp_ready);
  assign accept = req_valid && req_ready;
  assign ram_EN = accept || init_on;
  assign ram_WE = accept ? req_we : {4{init_on}};
  assign ram_A = accept ? req_addr : init_a;
  assign ram_Di = accept ? req_wdata : '0;
  assign rsp_valid = !RST && (rd_pend || hold_valid);
  assign rsp_rdata = !rsp_valid ? '0 : hold_valid ? hold : ram_Do;
  always_ff @(posedge CLK)
    if (RST) begin
      rd_pend <= 1'b0;
      hold_valid <= 1'b0;
      hold <= '0;
    end else begin
      rd_pend <= accept && req_we == 4'h0;
      if (rd_pend && !rsp_ready) begin
        hold <= ram_Do;
        hold_valid <= 1'b1;
      end else if (rsp_ready) hold_valid <= 1'b0;
    end
endmodule

// File: tb/tb_dffram_ctrl.sv
// tb_dffram_ctrl: scoreboard bench for dffram_ctrl with a behavioural DFFRAM and a word-array reference model.
module tb_dffram_ctrl;
  localparam int COLS = 2;
  localparam int AW = 9;
  localparam int DEPTH = 512;

  logic CLK = 0, RST = 1, busy, req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, ram_EN;
  logic [3:0] req_we = 0, ram_WE;
  logic [AW-1:0] req_addr = 0, ram_A;
  logic [31:0] req_wdata = 0, rsp_rdata, ram_Di, ram_Do = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  typedef struct {logic [31:0] data; int acc; bit seen;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, pass = 0, total = 0;
  bit rand_bp = 0;

  dffram_ctrl #(.COLS(COLS)) dut (
    .CLK(CLK), .RST(RST), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di), .ram_Do(ram_Do)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // DFFRAM behaviour: registered read of the old word, byte-lane writes, Do cleared when disabled
  always @(posedge CLK) begin
    logic [31:0] w;
    if (ram_EN) begin
      w = mem[ram_A];
      ram_Do <= w;
      for (int b = 0; b < 4; b++) if (ram_WE[b]) w[8*b +: 8] = ram_Di[8*b +: 8];
      mem[ram_A] <= w;
    end else ram_Do <= '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // monitor: every response cycle must carry the oldest outstanding read, one cycle after its accept
  always @(negedge CLK) begin
    if (rsp_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL spurious_rsp: rsp_valid=1 with rdata %h but no read outstanding at t=%0t", rsp_rdata, $time);
      end else begin
        e = q[0];
        chk("rsp_rdata", rsp_rdata, e.data);
        if (!e.seen) chk("rsp_latency", cyc, e.acc + 1);
        e.seen = 1;
        q[0] = e;
        if (rsp_ready) void'(q.pop_front());
      end
    end else chk("idle_rdata", rsp_rdata, 0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_req(input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d, output int waits);
    logic [31:0] m;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; waits = 0;
    @(negedge CLK);
    while (!req_ready && waits < 50) begin
      tick();
      if (rand_bp) rsp_ready = $urandom_range(0, 3) != 0;
      waits++;
      @(negedge CLK);
    end
    if (!req_ready) begin
      total++;
      $display("FAIL req_timeout: req_ready stayed 0 for addr %h, required 1 within 50 cycles", a);
    end else if (we == 4'h0) q.push_back('{ref_mem[a], cyc, 1'b0});
    else begin
      m = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
      ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
    end
    tick();
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    if (rand_bp) rsp_ready = $urandom_range(0, 3) != 0;
  endtask

  task automatic check_init();
`ifdef DFFRAM_CTRL_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      chk("init_busy", busy, 1);
      chk("init_en", ram_EN, 1);
      chk("init_we", ram_WE, 4'hF);
      chk("init_di", ram_Di, 0);
      chk("init_a", ram_A, i);
      chk("init_ready", req_ready, 0);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
`endif
    @(negedge CLK);
    chk("run_busy", busy, 0);
    chk("run_ready", req_ready, 1);
    chk("run_en", ram_EN, 0);
    chk("run_rsp_valid", rsp_valid, 0);
  endtask

  task automatic apply_reset();
    RST = 1; rsp_ready = 1; q.delete();
    req_valid = 1; req_we = 0; req_addr = 7;
    @(negedge CLK);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_en", ram_EN, 0);
    tick();
    RST = 0; req_valid = 0; req_addr = 0;
    check_init();
  endtask

  initial begin
    int w;
    logic [3:0] rw;
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    apply_reset();
    do_req(4'hF, 9'h010, 32'hDEADBEEF, w);
    do_req(4'h0, 9'h010, 32'h0, w);
    do_req(4'hF, 9'h005, 32'h11223344, w);
    do_req(4'b0101, 9'h005, 32'hAABBCCDD, w);
    do_req(4'h0, 9'h005, 32'h0, w);
    repeat (2) tick();
    rsp_ready = 0;
    do_req(4'h0, 9'h005, 32'h0, w);
    req_valid = 1; req_addr = 6;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'h11BB33DD);
      chk("bp_ready", req_ready, 0);
      tick();
    end
    req_valid = 0; req_addr = 0; rsp_ready = 1;
    @(negedge CLK);
    chk("bp_release_valid", rsp_valid, 1);
    chk("bp_release_ready", req_ready, 0);
    tick();
    @(negedge CLK);
    chk("bp_after_ready", req_ready, 1);
    chk("bp_after_valid", rsp_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      do_req(4'h0, AW'(i), 32'h0, w);
      chk("stream_nowait", w, 0);
    end
    tick();
    do_req(4'h0, 9'h003, 32'h0, w);
    apply_reset();
    do_req(4'hF, 9'h1FF, 32'h600DF00D, w);
    do_req(4'h0, 9'h1FF, 32'h0, w);
    do_req(4'h0, 9'h0AA, 32'h0, w);
    rand_bp = 1;
    repeat (300) begin
      rw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      v = $urandom;
      do_req(rw, $urandom_range(0, 3) == 0 ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 15)), v, w);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_bp = 0;
    rsp_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/dffram_ctrl.md
Name: dffram_ctrl

Overview:
- Initiator-side controller for the byte-writable 32-bit DFFRAM macro port (CLK/EN/WE[3:0]/Di/Do/A, one-cycle registered read, Do forced to 0 when EN low).
- Converts a valid/ready request stream plus a valid/ready read-response stream into DFFRAM pin activity.
- Captures read data in the single cycle it is valid and holds it under response backpressure.
- Sits between a bus slave adapter and the DFFRAM instance.

Parameters:
- COLS, 1, number of 256-word columns in the attached RAM; RAM depth is 256*COLS words.
- A_WIDTH (localparam), 8+$clog2(COLS), word address width.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous active-high reset.
- busy  out  1  high while the init sweep runs.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  4  byte write enables; 4'h0 means read.
- req_addr  in  A_WIDTH  word address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  read data present.
- rsp_ready  in  1  consumer takes data when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data.
- ram_EN  out  1  to DFFRAM EN.
- ram_WE  out  4  to DFFRAM WE.
- ram_A  out  A_WIDTH  to DFFRAM A.
- ram_Di  out  32  to DFFRAM Di.
- ram_Do  in  32  from DFFRAM Do.

Behaviour:
- Reset (RST high at posedge): rd_pend=0, hold_valid=0, hold=0; outputs busy=0 (1 if init enabled), rsp_valid=0, rsp_rdata=0, ram pins all 0, req_ready=0 during the reset cycle.
- States: INIT (optional), RUN. RUN is entered directly from reset when init is compiled out.
- req_ready = RUN && !hold_valid && !(rd_pend && !rsp_ready). This is combinational on rsp_ready by design.
- On accept, RAM pins are driven combinationally in the same cycle: ram_EN=1, ram_WE=req_we, ram_A=req_addr, ram_Di=req_wdata. With no accept: ram_EN=0, ram_WE=0, ram_A=0, ram_Di=0.
- Write (req_we!=0): no response generated; RAM updates at the accept edge.
- Read (req_we==0): rd_pend set at the accept edge. In the next cycle rsp_valid=1 and rsp_rdata=ram_Do.
  - Read latency: 1 cycle from accept to rsp_valid.
  - If rsp_ready=0 while rd_pend: hold<=ram_Do, hold_valid<=1.
  - While hold_valid: rsp_valid=1, rsp_rdata=hold. hold_valid clears on handshake.
- rsp_rdata = hold_valid ? hold : ram_Do. It equals 0 when rsp_valid=0.
- Back-to-back reads sustain 1 per cycle while rsp_ready=1. Responses are strictly in order. At most one response is outstanding beyond the pipeline stage.
- Write accepted in the rd_pend cycle is legal: ram_Do is sampled before the RAM updates Do.
- Partial byte writes touch only the enabled lanes.
- Address wrap: none. ram_A = req_addr; out-of-range addresses are not possible when COLS is a power of 2.
- Reset mid-operation: pending read and hold are discarded, no rsp_valid is emitted, and init (if enabled) restarts from word 0.

Optional Feature:
- Macro: DFFRAM_CTRL_INIT_EN.
- Defined:
  - After reset, INIT state sweeps a counter 0..256*COLS-1, one word per cycle, with ram_EN=1, ram_WE=4'hF, ram_Di=0, ram_A=counter.
  - busy=1 and req_ready=0 throughout.
  - After the last word (256*COLS cycles) the block moves to RUN and busy drops.
- Undefined: no counter or INIT state; busy is tied 0; RUN begins the cycle after RST deasserts.

Test Plan:
- Write 0xDEADBEEF @0x10 with WE=4'hF, then read @0x10, rsp_ready=1 -> rsp_valid exactly 1 cycle after read accept, rdata=0xDEADBEEF; no rsp for the write.
- Byte lanes: write 0x11223344 @5 (WE=F), then 0xAABBCCDD with WE=4'b0101, read @5 -> 0x11BB33DD.
- Backpressure: read @5 with rsp_ready=0 for 3 cycles -> rsp_valid held, rdata stable 0x11BB33DD, req_ready=0 throughout; on rsp_ready=1 one handshake, then req_ready=1.
- Streaming: 4 consecutive reads @0..3 with rsp_ready=1 -> 4 consecutive rsp cycles, in order, no bubbles.
- Reset mid-read: assert RST in the cycle after a read accept -> rsp_valid never asserts; controller idle after reset.
- DFFRAM_CTRL_INIT_EN, COLS=2: after reset busy=1 for 512 cycles, ram_WE=F and ram_Di=0 each cycle, addresses 0..511; then a read of any address returns 0.
